// File: rtl/args_packer.sv
// rtl/args_packer.sv - serial-to-parallel frame packer driving the adder tree args/we inputs
// Optional macro ARGS_PACKER_SOF_EN adds sof-based frame alignment and the drop_cnt counter.
module args_packer #(
  parameter int N_args    = 4,
  parameter int arg_width = 8,
  localparam int cnt_width = $clog2(N_args) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [arg_width-1:0]          din,
  input  logic                          din_valid,
  input  logic                          flush,
  output logic [N_args*arg_width-1:0]   args_out,
  output logic                          we,
  output logic [cnt_width-1:0]          fill_level,
  output logic [15:0]                   frame_cnt
`ifdef ARGS_PACKER_SOF_EN
  ,
  input  logic                          sof,
  output logic [7:0]                    drop_cnt
`endif
);

  localparam int FRAME_W = N_args * arg_width;
  localparam logic [cnt_width-1:0] FULL = cnt_width'(N_args);

  logic [FRAME_W-1:0]   r_stage;
  logic [FRAME_W-1:0]   r_args_out;
  logic                 r_we;
  logic [cnt_width-1:0] r_fill;
  logic [15:0]          r_frame_cnt;

  logic                 w_drop;
  logic [cnt_width-1:0] w_base_fill;
  logic [cnt_width-1:0] w_fill_wr;
  logic [FRAME_W-1:0]   w_stage_wr;
  logic                 w_emit;

  // A sof on a non-empty frame restarts packing from slot 0 with this sample.
`ifdef ARGS_PACKER_SOF_EN
  logic [7:0] r_drop_cnt;
  assign w_drop = din_valid & sof & (r_fill != '0);
`else
  assign w_drop = 1'b0;
`endif

  always_comb begin
    w_base_fill = w_drop ? '0 : r_fill;
    w_stage_wr  = w_drop ? '0 : r_stage;
    for (int k = 0; k < N_args; k++) begin
      if (din_valid && (w_base_fill == cnt_width'(k))) begin
        w_stage_wr[k*arg_width +: arg_width] = din;
      end
    end
    w_fill_wr = w_base_fill + cnt_width'(din_valid);
  end

  // The flush test uses the post-accept fill, so a completing sample plus flush emits once.
  assign w_emit = (w_fill_wr == FULL) | (flush & (w_fill_wr != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage     <= '0;
      r_args_out  <= '0;
      r_we        <= 1'b0;
      r_fill      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_we <= w_emit;
      if (w_emit) begin
        r_args_out  <= w_stage_wr;
        r_stage     <= '0;
        r_fill      <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_stage <= w_stage_wr;
        r_fill  <= w_fill_wr;
      end
    end
  end

`ifdef ARGS_PACKER_SOF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
  assign drop_cnt = r_drop_cnt;
`endif

  assign args_out   = r_args_out;
  assign we         = r_we;
  assign fill_level = r_fill;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_args_packer.sv
// tb/tb_args_packer.sv - randomized self-checking bench for args_packer (N_args=4 and N_args=1)
// Queue-based frame model checked every cycle, plus literal frame checks.
module tb_args_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic        flush = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  din = '0;

  logic [31:0] args_out;
  logic        we;
  logic [2:0]  fill_level;
  logic [15:0] frame_cnt;
  logic [7:0]  args1;
  logic        we1;
  logic [0:0]  fill1;
  logic [15:0] fc1;
`ifdef ARGS_PACKER_SOF_EN
  logic [7:0]  drop_cnt;
  logic [7:0]  drop1;
`endif

  args_packer #(.N_args(4), .arg_width(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .flush(flush),
    .args_out(args_out), .we(we), .fill_level(fill_level), .frame_cnt(frame_cnt)
`ifdef ARGS_PACKER_SOF_EN
    , .sof(sof), .drop_cnt(drop_cnt)
`endif
  );

  args_packer #(.N_args(1), .arg_width(8)) dut1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .flush(flush),
    .args_out(args1), .we(we1), .fill_level(fill1), .frame_cnt(fc1)
`ifdef ARGS_PACKER_SOF_EN
    , .sof(sof), .drop_cnt(drop1)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just the queue of accepted samples.
  byte unsigned mq[$];
  logic [31:0]  m_args = '0;
  logic         m_we = 1'b0;
  int           m_fc = 0;
  int           m_drop = 0;
  logic [7:0]   m1_args = '0;
  logic         m1_we = 1'b0;
  int           m1_fc = 0;
  bit           m_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_args = '0; m_we = 1'b0; m_fc = 0; m_drop = 0;
      m1_args = '0; m1_we = 1'b0; m1_fc = 0;
      m_ok = 1'b1;
    end else begin
      m_we = 1'b0;
`ifdef ARGS_PACKER_SOF_EN
      if (din_valid && sof && mq.size() > 0) begin
        mq.delete();
        if (m_drop < 255) m_drop++;
      end
`endif
      if (din_valid) mq.push_back(din);
      if (mq.size() == 4 || (flush && mq.size() > 0)) begin
        m_args = '0;
        foreach (mq[k]) m_args[k*8 +: 8] = mq[k];
        m_we = 1'b1;
        m_fc = (m_fc + 1) % 65536;
        mq.delete();
      end
      m1_we = din_valid;
      if (din_valid) begin
        m1_args = din;
        m1_fc = (m1_fc + 1) % 65536;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("we", we, m_we);
      check("args_out", args_out, m_args);
      check("fill_level", fill_level, mq.size());
      check("frame_cnt", frame_cnt, m_fc[15:0]);
      check("n1_we", we1, m1_we);
      check("n1_args_out", args1, m1_args);
      check("n1_fill_level", fill1, 0);
      check("n1_frame_cnt", fc1, m1_fc[15:0]);
`ifdef ARGS_PACKER_SOF_EN
      check("drop_cnt", drop_cnt, m_drop);
      check("n1_drop_cnt", drop1, 0);
`endif
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic s, input logic r);
    din_valid = v; din = d; flush = f; sof = s; reset = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] fc_before;

  initial begin
    step(0, 8'h00, 0, 0, 1);
    check("reset_we", we, 0);
    check("reset_args", args_out, 0);
    check("reset_fill", fill_level, 0);
    check("reset_fc", frame_cnt, 0);

    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    check("t1_no_we_early", we, 0);
    step(1, 8'h44, 0, 0, 0);
    check("t1_we", we, 1);
    check("t1_args", args_out, 32'h44332211);
    check("t1_fc", frame_cnt, 1);
    check("t1_fill", fill_level, 0);

    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 4) begin
        check("t2_we1", we, 1);
        check("t2_args1", args_out, 32'h04030201);
      end
      if (i == 5) begin
        check("t2_gap_we", we, 0);
        check("t2_hold", args_out, 32'h04030201);
      end
      if (i == 8) begin
        check("t2_we2", we, 1);
        check("t2_args2", args_out, 32'h08070605);
      end
    end
    check("t2_fc", frame_cnt, 3);

    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hBB, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("t3_we", we, 1);
    check("t3_args", args_out, 32'h0000BBAA);
    check("t3_fill", fill_level, 0);
    step(0, 8'h00, 1, 0, 0);
    check("t3_empty_flush_we", we, 0);
    check("t3_fc", frame_cnt, 4);

    fc_before = frame_cnt;
    step(1, 8'hC1, 0, 0, 0);
    step(1, 8'hC2, 0, 0, 0);
    step(1, 8'hC3, 0, 0, 0);
    step(1, 8'hC4, 1, 0, 0);
    check("t4_we", we, 1);
    check("t4_args", args_out, 32'hC4C3C2C1);
    step(0, 8'h00, 0, 0, 0);
    check("t4_single_we", we, 0);
    check("t4_fc", frame_cnt, fc_before + 16'd1);

`ifdef ARGS_PACKER_SOF_EN
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h09, 0, 1, 0);
    check("t5_fill_after_sof", fill_level, 1);
    step(1, 8'h0A, 0, 0, 0);
    step(1, 8'h0B, 0, 0, 0);
    step(1, 8'h0C, 0, 0, 0);
    check("t5_we", we, 1);
    check("t5_args", args_out, 32'h0C0B0A09);
    check("t5_drop", drop_cnt, 1);
`endif

    step(1, 8'hE1, 0, 0, 0);
    step(1, 8'hE2, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    check("t6_reset_we", we, 0);
    check("t6_reset_fc", frame_cnt, 0);
    step(1, 8'hF1, 0, 0, 0);
    step(1, 8'hF2, 0, 0, 0);
    step(1, 8'hF3, 0, 0, 0);
    check("t6_no_stale_we", we, 0);
    step(1, 8'hF4, 0, 0, 0);
    check("t6_we", we, 1);
    check("t6_args", args_out, 32'hF4F3F2F1);
    check("t6_fc", frame_cnt, 1);

    step(1, 8'h5A, 0, 0, 0);
    check("n1_we_lit", we1, 1);
    check("n1_args_lit", args1, 8'h5A);
    step(0, 8'h00, 1, 0, 0);
    check("n1_idle_we_lit", we1, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
